// File: rtl/beamformer_pkg.sv
// Constants and types shared between the array sample framer and the LMS beamformer.
package beamformer_pkg;

    localparam int BF_DW        = 16;
    localparam int BF_NCH       = 4;
    localparam int BF_FRAME_LEN = 8;
    localparam int BF_CW        = 16;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } framer_state_t;

    // Position of each word inside a frame; the reference follows the channels.
    localparam int CH1 = 0;
    localparam int CH2 = 1;
    localparam int CH3 = 2;
    localparam int CH4 = 3;
    localparam int REF = 4;

endpackage

// File: rtl/array_sample_framer_if.sv
// Time-multiplexed complex word stream from the acquisition interface into the framer.
interface array_sample_framer_if
    import beamformer_pkg::*;
#(
    parameter int DW = BF_DW
);
    logic          s_valid;
    logic          s_sof;
    logic [DW-1:0] s_re;
    logic [DW-1:0] s_im;
    logic          s_ready;

    modport master (output s_valid, output s_sof, output s_re, output s_im, input s_ready);
    modport slave  (input s_valid, input s_sof, input s_re, input s_im, output s_ready);
endinterface

// File: rtl/framer_spacing_timer.sv
// Commit spacing timer: permit rises once FRAME_LEN clocks have elapsed since the last commit.
module framer_spacing_timer
    import beamformer_pkg::*;
#(
    parameter int FRAME_LEN = BF_FRAME_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic permit
);
    localparam int RW = $clog2(FRAME_LEN + 1);

    // Clocks still owed before the next commit; zero out of reset so the first frame is never an overrun.
    logic [RW-1:0] rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
        end else if (clr) begin
            rem_q <= RW'(FRAME_LEN - 1);
        end else if (rem_q != '0) begin
            rem_q <= rem_q - 1'b1;
        end
    end

    assign permit = (rem_q == '0);
endmodule

// File: rtl/array_sample_framer.sv
// Assembles NCH channel words plus a reference word into a coherent, rate-limited parallel frame.
//   state   | meaning
//   HUNT    | waiting for an s_sof word, other words are dropped
//   COLLECT | staging channels 2..NCH and then the reference word
//   COMMIT  | one clock, s_ready low, outputs load if spacing permits
module array_sample_framer
    import beamformer_pkg::*;
#(
    parameter int DW        = BF_DW,
    parameter int NCH       = BF_NCH,
    parameter int FRAME_LEN = BF_FRAME_LEN,
    parameter int CW        = BF_CW
) (
    input  logic                   clk,
    input  logic                   rst,
    array_sample_framer_if.slave   s,
    input  logic                   err_clr,
    output logic [DW-1:0]          x1r,
    output logic [DW-1:0]          x1i,
    output logic [DW-1:0]          x2r,
    output logic [DW-1:0]          x2i,
    output logic [DW-1:0]          x3r,
    output logic [DW-1:0]          x3i,
    output logic [DW-1:0]          x4r,
    output logic [DW-1:0]          x4i,
    output logic [DW-1:0]          rr,
    output logic                   frame_valid,
    output logic [CW-1:0]          frame_cnt,
    output logic [CW-1:0]          drop_cnt,
    output logic                   err_seq,
    output logic                   err_ovr
);
    localparam int IW  = $clog2(NCH + 1);
    localparam int CHW = $clog2(NCH);

    framer_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          sof_err, stage_ch1, stage_next;
    logic          permit, commit_ok, commit_drop;

    logic [DW-1:0] stg_re [NCH];
    logic [DW-1:0] stg_im [NCH];
    logic [DW-1:0] stg_rr;
    logic [DW-1:0] out_re [NCH];
    logic [DW-1:0] out_im [NCH];
    logic [DW-1:0] out_rr;

    assign s.s_ready = (state_q != COMMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sof_err    = 1'b0;
        stage_ch1  = 1'b0;
        stage_next = 1'b0;
        case (state_q)
            HUNT: begin
                if (s.s_valid && s.s_sof) begin
                    stage_ch1 = 1'b1;
                    idx_d     = IW'(1);
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                if (s.s_valid) begin
                    if (s.s_sof) begin
                        sof_err   = 1'b1;
                        stage_ch1 = 1'b1;
                        idx_d     = IW'(1);
                    end else begin
                        stage_next = 1'b1;
                        if (idx_q == IW'(NCH)) begin
                            idx_d   = '0;
                            state_d = COMMIT;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            COMMIT: begin
                idx_d   = '0;
                state_d = HUNT;
            end
            default: begin
                idx_d   = '0;
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                stg_re[i] <= '0;
                stg_im[i] <= '0;
            end
            stg_rr <= '0;
        end else if (stage_ch1) begin
            stg_re[CH1] <= s.s_re;
            stg_im[CH1] <= s.s_im;
        end else if (stage_next) begin
            if (idx_q == IW'(NCH)) begin
                stg_rr <= s.s_re;
            end else begin
                stg_re[idx_q[CHW-1:0]] <= s.s_re;
                stg_im[idx_q[CHW-1:0]] <= s.s_im;
            end
        end
    end

    framer_spacing_timer #(.FRAME_LEN(FRAME_LEN)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (commit_ok),
        .permit (permit)
    );

    assign commit_ok   = (state_q == COMMIT) &&  permit;
    assign commit_drop = (state_q == COMMIT) && !permit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                out_re[i] <= '0;
                out_im[i] <= '0;
            end
            out_rr      <= '0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
            err_seq     <= 1'b0;
            err_ovr     <= 1'b0;
        end else begin
            frame_valid <= commit_ok;
            if (commit_ok) begin
                out_re    <= stg_re;
                out_im    <= stg_im;
                out_rr    <= stg_rr;
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (commit_drop) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            // A set event on the same edge as err_clr keeps the flag high.
            err_seq <= sof_err     | (err_seq & ~err_clr);
            err_ovr <= commit_drop | (err_ovr & ~err_clr);
        end
    end

    assign x1r = out_re[CH1];
    assign x1i = out_im[CH1];
    assign x2r = out_re[CH2];
    assign x2i = out_im[CH2];
    assign x3r = out_re[CH3];
    assign x3i = out_im[CH3];
    assign x4r = out_re[CH4];
    assign x4i = out_im[CH4];
    assign rr  = out_rr;
endmodule

// File: doc/array_sample_framer.md
Name: array_sample_framer

Overview:
- Front-end stage directly upstream of the 4-element complex LMS beamformer.
- Accepts one time-multiplexed complex word stream from the acquisition interface: channel 1..4 samples, then the reference word.
- Assembles each frame into parallel registers x1r..x4i and rr. Commits a frame atomically.
- Holds the committed outputs for at least FRAME_LEN clocks, so the beamformer's once-per-period latch always sees a coherent snapshot.

Parameters:
- DW, 16: sample width, two's complement.
- NCH, 4: antenna channels per frame. The reference word follows them, giving NCH+1 words per frame.
- FRAME_LEN, 8: minimum clocks between commits. Equals the beamformer's data period.
- CW, 16: frame/drop counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_sof  in  1  marks the channel-1 word of a frame. Qualified by s_valid.
- s_re  in  DW  input real part.
- s_im  in  DW  input imaginary part. Ignored for the reference word.
- s_ready  out  1  framer accepts a word this cycle.
- err_clr  in  1  clears the sticky error flags.
- x1r,x1i,x2r,x2i,x3r,x3i,x4r,x4i  out  DW each  committed channel samples.
- rr  out  DW  committed reference, real part.
- frame_valid  out  1  one-cycle pulse on each commit.
- frame_cnt  out  CW  committed frames. Wraps modulo 2^CW.
- drop_cnt  out  CW  frames dropped for overrun. Wraps.
- err_seq  out  1  sticky: s_sof seen mid-frame.
- err_ovr  out  1  sticky: frame completed too soon after the previous commit.

Behaviour:
- Reset:
  - All data outputs, frame_cnt, drop_cnt, err_seq, err_ovr and frame_valid are 0.
  - State is HUNT and the staging index is 0.
  - The spacing timer is preset to FRAME_LEN, so the first frame is never an overrun.
  - Reset mid-frame discards any partial staging content. Committed outputs go to 0.
- A word is accepted on a rising edge when s_valid && s_ready.
- s_ready is 1 in HUNT and COLLECT, and 0 in COMMIT.
- States:
  - HUNT: accepted words without s_sof are discarded silently. An accepted word with s_sof is staged as channel 1, index becomes 1, and the state goes to COLLECT.
  - COLLECT: each accepted word without s_sof is staged at the current index, and the index increments. Index 1..3 stage channels 2..4. Index 4 stages the reference, and the state goes to COMMIT.
  - COLLECT with s_sof on an accepted word: err_seq is set, the partial frame is abandoned, the word is staged as channel 1, and the index becomes 1. The state stays COLLECT.
  - COMMIT lasts exactly one clock. On its exiting edge the state returns to HUNT and the commit check is applied (see Spacing timer).
- Latency: the reference word is accepted on edge E. Outputs and frame_valid update on edge E+1. frame_valid is high for the single cycle after E+1.
- Spacing timer:
  - Counts clocks and saturates at FRAME_LEN. It clears to 1 on each successful commit edge.
  - A commit is permitted only if the timer is at least FRAME_LEN at the COMMIT exit edge, i.e. at least FRAME_LEN clocks have passed since the previous commit.
  - Permitted commit: copy staging to the outputs, pulse frame_valid, increment frame_cnt.
  - Not permitted: outputs are unchanged, no pulse, drop_cnt increments, err_ovr is set.
- Outputs change only on commit edges (or reset). There are no partial updates, and all nine output registers load on the same edge.
- Sticky flags:
  - err_clr clears err_seq and err_ovr on the next edge.
  - If a set event and err_clr occur on the same edge, the set wins.
- Counters wrap from 2^CW-1 to 0 with no flag.
- No arithmetic is performed; samples pass bit-exact.
- s_im of the reference word is discarded.

Decomposition:
- Shared package (beamformer_pkg):
  - DW, NCH and FRAME_LEN constants, shared with the LMS beamformer.
  - State enum: HUNT, COLLECT, COMMIT.
  - Word-index constants: CH1..CH4, REF.
- One sub-module is natural: framer_spacing_timer (saturating counter with clear and a permit output).
- The staging bank and FSM stay in the top module.

Test Plan:
- Back-to-back frames at 8-clock spacing: words (100,-100), (200,-200), (300,-300), (400,-400), ref (1234, 7) -> x1r=100, x1i=-100 … x4i=-400, rr=1234. frame_valid pulses one clock after the ref edge; frame_cnt=1, then 2 on the second frame; no errors.
- Mid-frame s_sof after 2 words, then a clean 5-word frame with x1r=0x7FFF -> err_seq=1, frame_cnt=1, x1r=0x7FFF; outputs were unchanged (0) before the commit.
- Two complete frames with 6-clock commit spacing -> second frame dropped: outputs retain frame-1 values, drop_cnt=1, err_ovr=1, frame_cnt=1.
- Leading words without s_sof, then s_valid gaps inside a frame -> leading words ignored; frame commits correctly when the ref arrives; s_ready=0 exactly during COMMIT.
- Assert rst after 3 words of a frame -> all outputs 0 and HUNT. A following valid frame commits with no err_ovr (timer preset).
- err_clr asserted on the same edge as a new s_sof violation -> err_seq stays 1. err_clr alone on a later edge -> err_seq=0.
